pslip_in_port: RTL and testbench

Input-port side of the pSLIP crossbar scheduler. Holds per-destination virtual output queues (VOQs) of packet priorities and presents one head priority per output to the output-side priority selectors. Receives their per-input grant bits and accepts exactly one grant per slot: highest priority first, ties broken by a round-robin accept pointer. Dequeues the accepted VOQ head.

---
 rtl/pslip_in_port.sv | 140 ++++++++++++++
 tb/tb_pslip_in_port.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pslip_in_port.sv
// Input-port side of the pSLIP scheduler: per-destination VOQs of priorities,
// head-priority requests per output, and a priority/round-robin grant accept.
module pslip_in_port #(
    parameter int unsigned N     = 4,
    parameter int unsigned P     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq_valid,
    input  logic [$clog2(N)-1:0] enq_dest,
    input  logic [$clog2(P)-1:0] enq_pri,
    output logic                 enq_ready,
    output logic [$clog2(P)-1:0] req_pri [0:N-1],
    input  logic                 gnt_valid,
    input  logic [N-1:0]         gnt,
    output logic                 acc_valid,
    output logic [$clog2(N)-1:0] acc_dest,
    output logic [$clog2(P)-1:0] acc_pri
);

    localparam int unsigned DW = $clog2(N);
    localparam int unsigned PW = $clog2(P);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StAcc} state_t;

    state_t state, state_d;

    logic [PW-1:0] mem    [N][DEPTH];
    logic [AW-1:0] wr_ptr [N];
    logic [AW-1:0] rd_ptr [N];
    logic [CW-1:0] count  [N];
    logic [PW-1:0] head   [N];

    logic [N-1:0]  nonempty;
    logic [N-1:0]  last_one;
    logic [N-1:0]  enq_hit;
    logic [N-1:0]  deq_hit;
    logic [N-1:0]  eff;
    logic          enq_fire;
    logic          any_after;
    logic [PW-1:0] enq_pri_st;
    logic [DW-1:0] acc_ptr;

    logic          sel_found;
    logic [DW-1:0] sel_dest;
    logic [PW-1:0] sel_pri;
    logic [DW-1:0] scan_idx;

    assign enq_ready  = (count[enq_dest] != CW'(DEPTH));
    assign enq_fire   = enq_valid && enq_ready;
    assign enq_pri_st = (enq_pri == '0) ? PW'(1) : enq_pri;
    assign eff        = gnt & nonempty;

    always_comb begin
        nonempty = '0;
        last_one = '0;
        enq_hit  = '0;
        deq_hit  = '0;
        for (int j = 0; j < N; j++) begin
            head[j]     = mem[j][rd_ptr[j]];
            nonempty[j] = (count[j] != '0);
            last_one[j] = (count[j] == CW'(1));
            enq_hit[j]  = enq_fire && (enq_dest == DW'(j));
            deq_hit[j]  = (state == StAcc) && (acc_dest == DW'(j));
            req_pri[j]  = (state == StReq && nonempty[j]) ? head[j] : '0;
        end
        // A VOQ draining its last entry only stays requestable if refilled now.
        any_after = (|(nonempty & ~(deq_hit & last_one))) || enq_fire;
    end

    // Strict '>' keeps the earliest candidate from acc_ptr on equal priority.
    always_comb begin
        sel_found = 1'b0;
        sel_dest  = '0;
        sel_pri   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = acc_ptr + DW'(k);
            if (eff[scan_idx] && (!sel_found || head[scan_idx] > sel_pri)) begin
                sel_found = 1'b1;
                sel_dest  = scan_idx;
                sel_pri   = head[scan_idx];
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            StIdle:  if (|nonempty || enq_fire) state_d = StReq;
            StReq:   if (gnt_valid && |eff) state_d = StAcc;
            StAcc:   state_d = any_after ? StReq : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            acc_ptr   <= '0;
            acc_valid <= 1'b0;
            acc_dest  <= '0;
            acc_pri   <= '0;
            for (int j = 0; j < N; j++) begin
                wr_ptr[j] <= '0;
                rd_ptr[j] <= '0;
                count[j]  <= '0;
            end
        end else begin
            state     <= state_d;
            acc_valid <= (state_d == StAcc);
            if (state == StReq && state_d == StAcc) begin
                acc_dest <= sel_dest;
                acc_pri  <= sel_pri;
            end
            if (state == StAcc) begin
                acc_ptr <= acc_dest + DW'(1);
            end
            for (int j = 0; j < N; j++) begin
                if (enq_hit[j]) wr_ptr[j] <= wr_ptr[j] + AW'(1);
                if (deq_hit[j]) rd_ptr[j] <= rd_ptr[j] + AW'(1);
                case ({enq_hit[j], deq_hit[j]})
                    2'b10:   count[j] <= count[j] + CW'(1);
                    2'b01:   count[j] <= count[j] - CW'(1);
                    default: count[j] <= count[j];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[enq_dest][wr_ptr[enq_dest]] <= enq_pri_st;
        end
    end

endmodule

// File: tb/tb_pslip_in_port.sv
// Directed bench for pslip_in_port: reset, single packet, priority/tie accept,
// grant to empty VOQ, zero priority, full/wrap FIFO order, mid-traffic reset.
module tb_pslip_in_port;

    logic       clk = 1'b0;
    logic       rst;
    logic       enq_valid;
    logic [1:0] enq_dest;
    logic [3:0] enq_pri;
    logic       enq_ready;
    logic [3:0] req_pri [0:3];
    logic       gnt_valid;
    logic [3:0] gnt;
    logic       acc_valid;
    logic [1:0] acc_dest;
    logic [3:0] acc_pri;

    int checks   = 0;
    int failures = 0;

    pslip_in_port #(.N(4), .P(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .enq_dest  (enq_dest),
        .enq_pri   (enq_pri),
        .enq_ready (enq_ready),
        .req_pri   (req_pri),
        .gnt_valid (gnt_valid),
        .gnt       (gnt),
        .acc_valid (acc_valid),
        .acc_dest  (acc_dest),
        .acc_pri   (acc_pri)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input int dest, input int pri);
        enq_valid = 1'b1;
        enq_dest  = 2'(dest);
        enq_pri   = 4'(pri);
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic grant(input logic [3:0] g);
        gnt_valid = 1'b1;
        gnt       = g;
        tick();
        gnt_valid = 1'b0;
        gnt       = '0;
    endtask

    task automatic check_req_zero(input string tag);
        for (int j = 0; j < 4; j++) check(tag, int'(req_pri[j]), 0);
    endtask

    initial begin
        rst       = 1'b1;
        enq_valid = 1'b0;
        enq_dest  = '0;
        enq_pri   = '0;
        gnt_valid = 1'b0;
        gnt       = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_acc_valid", int'(acc_valid), 0);
        check("rst_acc_dest", int'(acc_dest), 0);
        check("rst_acc_pri", int'(acc_pri), 0);
        check("rst_enq_ready", int'(enq_ready), 1);
        check_req_zero("rst_req_pri");

        // Single packet
        enq(2, 5);
        check("single_req2", int'(req_pri[2]), 5);
        check("single_req0", int'(req_pri[0]), 0);
        grant(4'b0100);
        check("single_acc_valid", int'(acc_valid), 1);
        check("single_acc_dest", int'(acc_dest), 2);
        check("single_acc_pri", int'(acc_pri), 5);
        check("single_acc_req2", int'(req_pri[2]), 0);
        tick();
        check("single_after_valid", int'(acc_valid), 0);
        check("single_hold_dest", int'(acc_dest), 2);
        check("single_hold_pri", int'(acc_pri), 5);
        check_req_zero("single_idle_req");
        check("single_ptr", int'(dut.acc_ptr), 3);

        // Move acc_ptr to 2 by accepting dest 1
        enq(1, 1);
        grant(4'b0010);
        check("ptr_setup_dest", int'(acc_dest), 1);
        tick();
        check("ptr_setup", int'(dut.acc_ptr), 2);

        // Priority accept with tie broken from pointer 2
        enq(0, 3);
        enq(1, 9);
        enq(3, 9);
        check("prio_req0", int'(req_pri[0]), 3);
        check("prio_req1", int'(req_pri[1]), 9);
        check("prio_req3", int'(req_pri[3]), 9);
        grant(4'b1011);
        check("prio1_valid", int'(acc_valid), 1);
        check("prio1_dest", int'(acc_dest), 3);
        check("prio1_pri", int'(acc_pri), 9);
        tick();
        check("prio1_ptr", int'(dut.acc_ptr), 0);
        grant(4'b1011);
        check("prio2_dest", int'(acc_dest), 1);
        check("prio2_pri", int'(acc_pri), 9);
        tick();
        grant(4'b0001);
        check("prio3_dest", int'(acc_dest), 0);
        check("prio3_pri", int'(acc_pri), 3);
        tick();
        check("prio3_ptr", int'(dut.acc_ptr), 1);
        check_req_zero("prio_idle_req");

        // Grant to empty VOQ is lost
        enq(2, 7);
        grant(4'b0001);
        check("empty_gnt_valid", int'(acc_valid), 0);
        check("empty_gnt_req2", int'(req_pri[2]), 7);
        check("empty_gnt_ptr", int'(dut.acc_ptr), 1);
        check("empty_gnt_hold", int'(acc_dest), 0);
        grant(4'b0100);
        check("empty_next_valid", int'(acc_valid), 1);
        check("empty_next_dest", int'(acc_dest), 2);
        check("empty_next_pri", int'(acc_pri), 7);
        tick();

        // Zero priority stored as 1
        enq(0, 0);
        check("zero_req0", int'(req_pri[0]), 1);
        grant(4'b0001);
        check("zero_acc_dest", int'(acc_dest), 0);
        check("zero_acc_pri", int'(acc_pri), 1);
        tick();

        // Fill VOQ1
        for (int i = 1; i <= 4; i++) enq(1, i);
        enq_dest = 2'd1;
        #1;
        check("full_ready1", int'(enq_ready), 0);
        enq_dest = 2'd0;
        #1;
        check("full_ready0", int'(enq_ready), 1);
        enq_dest = 2'd3;
        #1;
        check("full_ready3", int'(enq_ready), 1);

        // Offer into full VOQ during its dequeue: rejected, then accepted
        grant(4'b0010);
        enq_valid = 1'b1;
        enq_dest  = 2'd1;
        enq_pri   = 4'd5;
        #1;
        check("deq_full_ready", int'(enq_ready), 0);
        check("deq_full_acc", int'(acc_valid), 1);
        check("deq_full_pri", int'(acc_pri), 1);
        tick();
        check("deq_next_ready", int'(enq_ready), 1);
        check("deq_next_head", int'(req_pri[1]), 2);
        tick();
        enq_valid = 1'b0;
        check("refull_ready", int'(enq_ready), 0);

        // Cycle packets through VOQ1 across pointer wrap
        for (int k = 0; k < 9; k++) begin
            grant(4'b0010);
            check($sformatf("wrap_pri_%0d", k), int'(acc_pri), 2 + k);
            tick();
            enq(1, 6 + k);
        end
        for (int k = 0; k < 4; k++) begin
            grant(4'b0010);
            check($sformatf("drain_pri_%0d", k), int'(acc_pri), 11 + k);
            tick();
        end
        check("drain_idle_valid", int'(acc_valid), 0);
        check_req_zero("drain_idle_req");

        // Reset mid-traffic with an accept pending
        enq(0, 4);
        enq(3, 6);
        gnt_valid = 1'b1;
        gnt       = 4'b1001;
        rst       = 1'b1;
        tick();
        check("midrst_acc_valid", int'(acc_valid), 0);
        gnt_valid = 1'b0;
        gnt       = '0;
        tick();
        rst = 1'b0;
        check("midrst_acc_dest", int'(acc_dest), 0);
        check("midrst_acc_pri", int'(acc_pri), 0);
        check("midrst_ptr", int'(dut.acc_ptr), 0);
        enq_dest = 2'd3;
        #1;
        check("midrst_ready", int'(enq_ready), 1);
        check_req_zero("midrst_req");
        grant(4'b1001);
        check("midrst_gnt_valid", int'(acc_valid), 0);
        tick();
        check("midrst_gnt_valid2", int'(acc_valid), 0);
        enq(3, 2);
        check("midrst_new_req3", int'(req_pri[3]), 2);
        check("midrst_new_req0", int'(req_pri[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
